conv_encoder_k3: RTL
====================

Name: conv_encoder_k3

Overview:
- Rate-1/2, constraint-length-3 convolutional encoder. It produces the coded symbol stream that the Viterbi decoder datapath (BMC/ACS/traceback) consumes.
- Accepts framed serial data bits over a valid/ready handshake.
- Emits one 2-bit symbol per data bit, then appends K-1=2 zero tail bits so every frame terminates in state 0, which the decoder traceback relies on.
- Sits at the head of the loopback test path ahead of the channel-error injector.

Parameters:
FRAME_LEN, 16, data bits per frame (legal range 1..255); tail bits not included
G0, 3'b111, generator for sym_o[1]; bit2 taps current input, bit1 taps s1, bit0 taps s2
G1, 3'b101, generator for sym_o[0]; same bit mapping as G0

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
start_i  in  1  single-cycle pulse; opens a frame when in IDLE, ignored otherwise
din_valid_i  in  1  data bit valid
din_i  in  1  data bit
din_ready_o  out  1  encoder accepts din_i this cycle
sym_valid_o  out  1  output symbol valid
sym_o  out  2  coded symbol {g0,g1}
sym_ready_i  in  1  downstream accepts symbol
sym_last_o  out  1  marks the final (second tail) symbol of a frame
busy_o  out  1  high from frame start until the last symbol is accepted
frame_done_o  out  1  one-cycle pulse on the cycle the last symbol is accepted

Behaviour:
- Reset (async assert, sync release): state IDLE; shift register {s1,s2}=2'b00; bit counter 0; output register empty.
- Reset values of outputs: sym_valid_o=0, sym_o=0, sym_last_o=0, din_ready_o=0, busy_o=0, frame_done_o=0.
- Encoding with u = current input bit:
  - sym_o[1] = ^(G0 & {u,s1,s2})
  - sym_o[0] = ^(G1 & {u,s1,s2})
  - On each encode: s2<=s1, s1<=u.
- Output stage: one register (sym_o/sym_valid_o/sym_last_o). It is "free" when empty or when sym_ready_i is high this cycle. Encoding happens only when free.
- Handshake: a symbol transfers when sym_valid_o && sym_ready_i. sym_o and sym_last_o hold stable while sym_valid_o=1 and sym_ready_i=0.
- FSM states and transitions:
  - IDLE: din_ready_o=0. start_i -> DATA; clears the counter and shift register in the same cycle.
  - DATA: din_ready_o = output free. A bit transfers when din_valid_i && din_ready_o; it is encoded and the counter increments. When the FRAME_LEN-th bit transfers -> TAIL, counter cleared.
  - TAIL: din_ready_o=0. When output is free, encode u=0 and increment the counter. The second tail encode sets sym_last_o -> DRAIN.
  - DRAIN: wait for the last symbol to transfer. Then pulse frame_done_o, drop busy_o -> IDLE. A start_i in that same cycle is ignored; a new frame needs start_i in IDLE.
- Latency: symbol is valid the cycle after its data bit is accepted.
- Throughput: 1 symbol/clk with sym_ready_i held high. A frame is FRAME_LEN+2 symbols.
- The frame ends with {s1,s2}=2'b00.
- busy_o is high in DATA/TAIL/DRAIN.
- Backpressure: with sym_ready_i=0 and the output full, din_ready_o=0 and the tail does not advance. No symbol is dropped or duplicated.
- din_valid_i outside DATA is ignored.
- Reset mid-frame: the frame is abandoned immediately and outputs take their reset values; no frame_done_o pulse.
- Counter is 8 bits wide and never wraps within a legal FRAME_LEN.

Optional Feature:
- Macro: CONV_ENC_SYMCNT_EN.
- When defined:
  - Adds output port sym_cnt_o [15:0]: count of symbols transferred since reset, incremented on each sym_valid_o && sym_ready_i.
  - Saturates at 16'hFFFF; cleared only by rst.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- FRAME_LEN=4, sym_ready_i=1, start_i then bits 1,0,1,1 back-to-back -> sym_o sequence 11,10,00,01,01,11 on consecutive cycles; sym_last_o only on the 6th; one frame_done_o pulse; busy_o high exactly 7 cycles.
- Same frame with sym_ready_i toggling 1,0,1,0 -> identical symbol sequence; each held symbol stable while unaccepted; din_ready_o=0 whenever the output is full and not accepted.
- Default FRAME_LEN=16, all-zero data -> 18 symbols of 00; final {s1,s2}=00; frame_done_o once.
- Assert rst on the 3rd data bit of a frame -> all outputs at reset values the same cycle; next start_i with bits 1,0,1,1 (FRAME_LEN=4) reproduces 11,10,00,01,01,11.
- din_valid_i=1 while in IDLE and a start_i during TAIL -> no symbols produced in IDLE; frame unaffected; no second frame begins.
- With CONV_ENC_SYMCNT_EN: two FRAME_LEN=4 frames -> sym_cnt_o=12; after rst, sym_cnt_o=0.

Source files
------------

// File: rtl/conv_encoder_k3.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// conv_encoder_k3
//   Rate-1/2, constraint-length-3 convolutional encoder. Each frame is
//   FRAME_LEN serial data bits. Every bit becomes one 2-bit symbol {g0,g1}.
//   Two zero tail bits follow the data, so the encoder always ends a frame in
//   state 0. The Viterbi traceback downstream depends on that final state.
//
// Parameters
//   FRAME_LEN  data bits per frame, 1..255 (tail not included)
//   G0         generator for sym_o[1]; bit2=u, bit1=s1, bit0=s2
//   G1         generator for sym_o[0]; same tap mapping
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   start_i         opens a frame when idle; ignored at any other time
//   din_valid_i/din_i/din_ready_o   serial data bit handshake
//   sym_valid_o/sym_o/sym_ready_i   coded symbol handshake
//   sym_last_o      marks the second tail symbol of the frame
//   busy_o          frame in progress (from start until last symbol accepted)
//   frame_done_o    one-cycle pulse when the last symbol is accepted
//   sym_cnt_o       (only with CONV_ENC_SYMCNT_EN) saturating count of
//                   symbols transferred since reset
//
// Build option
//   CONV_ENC_SYMCNT_EN  adds the sym_cnt_o port and its counter
// -----------------------------------------------------------------------------
module conv_encoder_k3 #(
    parameter int unsigned FRAME_LEN = 16,
    parameter logic [2:0]  G0        = 3'b111,
    parameter logic [2:0]  G1        = 3'b101
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        din_valid_i,
    input  logic        din_i,
    output logic        din_ready_o,
    output logic        sym_valid_o,
    output logic [1:0]  sym_o,
    input  logic        sym_ready_i,
    output logic        sym_last_o,
    output logic        busy_o,
    output logic        frame_done_o
`ifdef CONV_ENC_SYMCNT_EN
    ,
    output logic [15:0] sym_cnt_o
`endif
);

    typedef enum logic [1:0] {IDLE, DATA, TAIL, DRAIN} state_t;

    localparam logic [7:0] LAST_DATA = 8'(FRAME_LEN - 1);

    state_t     state, state_nx;
    logic [7:0] cnt, cnt_nx;
    logic [1:0] sreg, sreg_nx;     // {s1,s2}
    logic       out_free;
    logic       sym_xfer;
    logic       enc_en;
    logic       enc_u;
    logic       enc_last;
    logic [2:0] taps;

    // The output register can accept a new symbol when it is empty, or when
    // its current symbol leaves during this cycle.
    assign out_free = !sym_valid_o || sym_ready_i;
    assign sym_xfer = sym_valid_o && sym_ready_i;
    assign taps     = {enc_u, sreg};
    assign busy_o   = (state != IDLE);

    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        sreg_nx      = sreg;
        enc_en       = 1'b0;
        enc_u        = 1'b0;
        enc_last     = 1'b0;
        din_ready_o  = 1'b0;
        frame_done_o = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_nx = DATA;
                    cnt_nx   = 8'd0;
                    sreg_nx  = 2'b00;
                end
            end
            DATA: begin
                din_ready_o = out_free;
                if (din_valid_i && out_free) begin
                    enc_en = 1'b1;
                    enc_u  = din_i;
                    if (cnt == LAST_DATA) begin
                        state_nx = TAIL;
                        cnt_nx   = 8'd0;
                    end else begin
                        cnt_nx = cnt + 8'd1;
                    end
                end
            end
            TAIL: begin
                // The tail is encoded only when the output register has room,
                // so backpressure stalls the tail in the same way as the data.
                if (out_free) begin
                    enc_en = 1'b1;
                    cnt_nx = cnt + 8'd1;
                    if (cnt == 8'd1) begin
                        enc_last = 1'b1;
                        state_nx = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // The only symbol left in the register is the last one.
                if (sym_xfer) begin
                    frame_done_o = 1'b1;
                    state_nx     = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (enc_en)
            sreg_nx = {enc_u, sreg[1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 8'd0;
            sreg  <= 2'b00;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            sreg  <= sreg_nx;
        end
    end

    // Output register. If no new symbol is written, the current symbol is
    // held until it is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sym_valid_o <= 1'b0;
            sym_o       <= 2'b00;
            sym_last_o  <= 1'b0;
        end else if (enc_en) begin
            sym_valid_o <= 1'b1;
            sym_o       <= {^(G0 & taps), ^(G1 & taps)};
            sym_last_o  <= enc_last;
        end else if (sym_ready_i) begin
            sym_valid_o <= 1'b0;
            sym_last_o  <= 1'b0;
        end
    end

`ifdef CONV_ENC_SYMCNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sym_cnt_o <= 16'd0;
        else if (sym_xfer && (sym_cnt_o != 16'hFFFF))
            sym_cnt_o <= sym_cnt_o + 16'd1;
    end
`endif

endmodule
